// File: rtl/cpu_ctrl_if.sv
// Control bus between cpu_control_fsm and the 8-bit datapath: instruction in, strobes and status out.
interface cpu_ctrl_if;
  logic [7:0] instruction;
  logic       reg_write;
  logic       mem_write;
  logic       alu_src;
  logic       pc_write;
  logic       imm_signed;
  logic [2:0] alu_op;
  logic       mem_to_reg;
  logic [2:0] state_out;
  logic       halted;
  logic       illegal_op;

  modport master (
    input  instruction,
    output reg_write, mem_write, alu_src, pc_write, imm_signed,
           alu_op, mem_to_reg, state_out, halted, illegal_op
  );

  modport slave (
    output instruction,
    input  reg_write, mem_write, alu_src, pc_write, imm_signed,
           alu_op, mem_to_reg, state_out, halted, illegal_op
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 8-bit CPU; all strobes registered (Moore).
// Optional single-step gating in FETCH is enabled by defining CTRL_STEP_EN.
module cpu_control_fsm #(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CTRL_STEP_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  cpu_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_op;
  logic       r_reg_write;
  logic       r_mem_write;
  logic       r_alu_src;
  logic       r_pc_write;
  logic       r_imm_signed;
  logic [2:0] r_alu_op;
  logic       r_mem_to_reg;
  logic       r_halted;
  logic       r_illegal_op;

  state_t     w_next_state;
  logic [3:0] w_next_op;
  logic [3:0] w_dec_op;
  logic       w_fetch_go;
  logic       w_operand_phase;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op != HALT_OPCODE);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == 4'h8) || (op == 4'h9);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      4'h2:       return 3'b001;
      4'h3:       return 3'b010;
      4'h4:       return 3'b011;
      4'h5:       return 3'b100;
      4'h8, 4'h9: return 3'b101;
      default:    return 3'b000;
    endcase
  endfunction

  assign w_dec_op = bus.instruction[7:4];

`ifdef CTRL_STEP_EN
  assign w_fetch_go = !step_mode || step;
`else
  assign w_fetch_go = 1'b1;
`endif

  always_comb begin
    w_next_state = S_FETCH;
    w_next_op    = r_op;
    case (r_state)
      S_FETCH:  w_next_state = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next_op = w_dec_op;
        if (w_dec_op == HALT_OPCODE)
          w_next_state = S_HALT;
        else if (w_dec_op == 4'h0 || is_illegal(w_dec_op))
          w_next_state = S_WB;
        else
          w_next_state = S_EXEC;
      end
      S_EXEC:   w_next_state = is_mem_op(r_op) ? S_MEM : S_WB;
      S_MEM:    w_next_state = S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Outputs are decoded from the upcoming state/opcode so they register in step with the state.
  assign w_operand_phase = (w_next_state == S_EXEC) || (w_next_state == S_MEM) ||
                           (w_next_state == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_op         <= 4'h0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_pc_write   <= 1'b0;
      r_imm_signed <= 1'b0;
      r_alu_op     <= 3'b000;
      r_mem_to_reg <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_op         <= w_next_op;
      r_alu_op     <= w_operand_phase ? alu_op_of(w_next_op) : 3'b000;
      r_alu_src    <= w_operand_phase && (w_next_op == 4'h6 || w_next_op == 4'h7);
      r_imm_signed <= w_operand_phase && (w_next_op == 4'h7);
      r_mem_write  <= (w_next_state == S_MEM) && (w_next_op == 4'h9);
      r_mem_to_reg <= (w_next_state == S_MEM || w_next_state == S_WB) && (w_next_op == 4'h8);
      r_pc_write   <= (w_next_state == S_WB);
      r_reg_write  <= (w_next_state == S_WB) && (w_next_op >= 4'h1) && (w_next_op <= 4'h8);
      r_halted     <= (w_next_state == S_HALT);
      r_illegal_op <= r_illegal_op || ((r_state == S_DECODE) && is_illegal(w_dec_op));
    end
  end

  assign bus.state_out  = r_state;
  assign bus.reg_write  = r_reg_write;
  assign bus.mem_write  = r_mem_write;
  assign bus.alu_src    = r_alu_src;
  assign bus.pc_write   = r_pc_write;
  assign bus.imm_signed = r_imm_signed;
  assign bus.alu_op     = r_alu_op;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.halted     = r_halted;
  assign bus.illegal_op = r_illegal_op;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed program plus random instructions vs. a per-instruction cycle model.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef CTRL_STEP_EN
  logic step_mode = 1'b0;
  logic step = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;
  bit model_ill = 1'b0;
  logic [2:0] alu_tab [16];

  cpu_ctrl_if bus();

  cpu_control_fsm #(.HALT_OPCODE(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CTRL_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int st, input bit hlt, input bit ill);
    chk({tag, ".state"},      8'(bus.state_out), 8'(st));
    chk({tag, ".reg_write"},  8'(bus.reg_write), 8'h0);
    chk({tag, ".mem_write"},  8'(bus.mem_write), 8'h0);
    chk({tag, ".pc_write"},   8'(bus.pc_write), 8'h0);
    chk({tag, ".alu_src"},    8'(bus.alu_src), 8'h0);
    chk({tag, ".imm_signed"}, 8'(bus.imm_signed), 8'h0);
    chk({tag, ".alu_op"},     8'(bus.alu_op), 8'h0);
    chk({tag, ".mem_to_reg"}, 8'(bus.mem_to_reg), 8'h0);
    chk({tag, ".halted"},     8'(bus.halted), 8'(hlt));
    chk({tag, ".illegal_op"}, 8'(bus.illegal_op), 8'(ill));
  endtask

  // Called at the falling edge of a FETCH cycle; returns at the falling edge of the next FETCH.
  task automatic run_instr(input logic [7:0] instr, input string tag);
    int seq[$];
    logic [3:0] op;
    bit bad;
    int s;
    op  = instr[7:4];
    bad = (op >= 4'hA) && (op <= 4'hE);
    bus.instruction = instr;
    if (op == 4'h0 || bad)            seq = '{0, 1, 4};
    else if (op == 4'h8 || op == 4'h9) seq = '{0, 1, 2, 3, 4};
    else                               seq = '{0, 1, 2, 4};
    for (int k = 0; k < seq.size(); k++) begin
      s = seq[k];
      if (k == 2) model_ill = model_ill | bad;
      chk({tag, ".state"},      8'(bus.state_out),  8'(s));
      chk({tag, ".pc_write"},   8'(bus.pc_write),   8'(s == 4));
      chk({tag, ".reg_write"},  8'(bus.reg_write),  8'((s == 4) && op >= 1 && op <= 8));
      chk({tag, ".mem_write"},  8'(bus.mem_write),  8'((s == 3) && op == 9));
      chk({tag, ".mem_to_reg"}, 8'(bus.mem_to_reg), 8'((s == 3 || s == 4) && op == 8));
      chk({tag, ".alu_src"},    8'(bus.alu_src),    8'((s >= 2) && (op == 6 || op == 7)));
      chk({tag, ".imm_signed"}, 8'(bus.imm_signed), 8'((s >= 2) && op == 7));
      chk({tag, ".alu_op"},     8'(bus.alu_op),     8'((s >= 2) ? alu_tab[op] : 3'b000));
      chk({tag, ".halted"},     8'(bus.halted),     8'h0);
      chk({tag, ".illegal_op"}, 8'(bus.illegal_op), 8'(model_ill));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rnd;
    foreach (alu_tab[i]) alu_tab[i] = 3'b000;
    alu_tab[2] = 3'b001; alu_tab[3] = 3'b010; alu_tab[4] = 3'b011;
    alu_tab[5] = 3'b100; alu_tab[8] = 3'b101; alu_tab[9] = 3'b101;
    bus.instruction = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;

    // Directed program from the test plan
    run_instr(8'h14, "add");
    run_instr(8'h7F, "addis");
    run_instr(8'h81, "ld");
    run_instr(8'h92, "st");
    run_instr(8'h06, "nop");
    run_instr(8'hB0, "illegal");
    run_instr(8'h55, "xor_after_ill");

    // Reset during EXEC of SUB
    bus.instruction = 8'h25;
    @(negedge clk);
    chk("sub.decode", 8'(bus.state_out), 8'd1);
    @(negedge clk);
    chk("sub.exec", 8'(bus.state_out), 8'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ill = 1'b0;
    chk_idle("sub_reset", 0, 1'b0, 1'b0);
    run_instr(8'h25, "sub_retry");

`ifdef CTRL_STEP_EN
    step_mode = 1'b1;
    step = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("step.hold", 8'(bus.state_out), 8'd0);
    end
    step = 1'b1;
    run_instr(8'h36, "step.and");
    step = 1'b0;
    @(negedge clk);
    chk("step.hold2", 8'(bus.state_out), 8'd0);
    step_mode = 1'b0;
    @(negedge clk);
    chk("step.free", 8'(bus.state_out), 8'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("step.free_fetch", 8'(bus.state_out), 8'd0);
`endif

    // Random instructions (HALT excluded)
    for (int n = 0; n < 60; n++) begin
      rnd = 8'($urandom);
      rnd[7:4] = 4'($urandom_range(0, 14));
      run_instr(rnd, $sformatf("rnd%0d_%02h", n, rnd));
    end

    // HALT parks for 20 cycles with no strobes, reset exits
    bus.instruction = 8'hF0;
    chk("halt.fetch", 8'(bus.state_out), 8'd0);
    @(negedge clk);
    chk("halt.decode", 8'(bus.state_out), 8'd1);
    chk("halt.decode_halted", 8'(bus.halted), 8'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_idle($sformatf("halt%0d", c), 5, 1'b1, model_ill);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ill = 1'b0;
    chk_idle("halt_reset", 0, 1'b0, 1'b0);
    run_instr(8'h43, "or_after_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit for the 8-bit CPU datapath. It samples the instruction the datapath exports, latches its opcode, and walks a FETCH/DECODE/EXEC/MEM/WB state machine. In each state it drives the datapath strobes `reg_write`, `mem_write`, `alu_src`, `pc_write`, `imm_signed`, `alu_op` and `mem_to_reg`. It sits beside the datapath at CPU top level and is the only source of those control inputs.

## Interface
- `HALT_OPCODE`, default 4'hF: opcode that parks the FSM in HALT.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `instruction`  input  8  current instruction from the datapath; [7:4] is the opcode.
- `reg_write`  output  1  register file write strobe.
- `mem_write`  output  1  data memory write strobe.
- `alu_src`  output  1  ALU operand B select: 1 = immediate, 0 = register.
- `pc_write`  output  1  PC advance strobe; one pulse per retired instruction.
- `imm_signed`  output  1  1 = sign-extend imm4, 0 = zero-extend.
- `alu_op`  output  3  ALU function select.
- `mem_to_reg`  output  1  writeback source: 1 = data memory, 0 = ALU.
- `state_out`  output  3  current state encoding, for debug.
- `halted`  output  1  high while in HALT.
- `illegal_op`  output  1  sticky flag; set when an undefined opcode is decoded.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Any other value goes to FETCH on the next edge.
- FETCH → DECODE unconditionally. This cycle lets the instruction memory output settle.
- DECODE latches `instruction[7:4]` into `op_q`. Next state:
  - HALT if the opcode equals `HALT_OPCODE`.
  - WB if NOP or illegal.
  - EXEC otherwise.
- EXEC → MEM for LD/ST; EXEC → WB for all other opcodes.
- MEM → WB. WB → FETCH. HALT → HALT; only `reset` exits HALT.
- Opcode map, with the `alu_op` value driven:
  - 0 NOP.
  - 1 ADD, alu_op 000.
  - 2 SUB, 001.
  - 3 AND, 010.
  - 4 OR, 011.
  - 5 XOR, 100.
  - 6 ADDI, 000 with `alu_src`=1, `imm_signed`=0.
  - 7 ADDIS, 000 with `alu_src`=1, `imm_signed`=1.
  - 8 LD, 101 (PASS_A).
  - 9 ST, 101 (PASS_A).
  - A–E illegal.
  - F HALT.
- Operand drive: `alu_op`, `alu_src` and `imm_signed` are decoded from `op_q` and held constant from EXEC through WB. They are 0 in FETCH, DECODE and HALT.
- MEM state: `mem_write`=1 only for ST.
- WB state:
  - `pc_write`=1 for every opcode except HALT.
  - `reg_write`=1 for opcodes 1–8.
  - `mem_to_reg`=1 for LD, held from MEM through WB.
- Illegal opcodes are retired as NOP: PC advances, no register or memory write, and `illegal_op` is set. `illegal_op` clears only on reset.
- All strobe outputs are Moore, decoded from the state register and `op_q`; they have no combinational path from `instruction`.

## Timing
- Reset values: state FETCH, `op_q`=0, and every output 0 except `state_out`=0.
- Cycles per instruction, measured from entering FETCH to the next FETCH:
  - ALU and immediate ops: 4.
  - LD/ST: 5.
  - NOP/illegal: 3.
- `pc_write` is exactly one cycle wide, in WB. The PC updates on the same edge that closes WB.
- `reg_write` coincides with `pc_write`. The register write uses the `reg_dst` of the instruction still on the bus, because the PC changes at that same edge.
- `mem_write` is exactly one cycle wide, in MEM, and never overlaps `reg_write`.
- Reset asserted in any state: on the next edge state goes to FETCH, all strobes drop, and `halted` and `illegal_op` clear. A write strobe present in the reset cycle is not suppressed combinationally.
- `halted` rises on the edge entering HALT and stays high. `pc_write` is never asserted for the HALT instruction, so the PC stays on it.

## Configuration
- `CTRL_STEP_EN` defined:
  - Adds ports `step_mode` (input, 1) and `step` (input, 1).
  - While `step_mode`=1, the FSM holds in FETCH until `step`=1 is sampled. That sample advances exactly one instruction.
  - Holding `step` high retires one instruction per pass through FETCH.
  - `step_mode`=0 gives free-running behaviour.
- `CTRL_STEP_EN` undefined: the ports are absent and FETCH always advances.

## Test plan
- Reset, then instruction 8'h1_4 (ADD) → states 0,1,2,4,0. In WB: `reg_write`=1, `pc_write`=1, `alu_op`=000, `alu_src`=0.
- Instruction 8'h7_F (ADDIS) → in EXEC and WB: `alu_src`=1, `imm_signed`=1, `alu_op`=000. One `pc_write` pulse.
- LD 8'h8_1 then ST 8'h9_2:
  - LD → `mem_to_reg`=1 in MEM and WB, and `reg_write` in WB only.
  - ST → `mem_write`=1 for one cycle in MEM, and `reg_write` never asserted.
  - Each takes 5 cycles.
- Instruction 8'hB_0 → 3-cycle retire, `pc_write` pulses, no writes, `illegal_op` stays 1 afterward.
- Instruction 8'hF_0 → `halted`=1, FSM stays in HALT for 20 cycles with no strobes. Then `reset` → FETCH, `halted`=0.
- Reset asserted during EXEC of SUB (8'h2_5) → next cycle state 0, no `reg_write`/`pc_write` pulse. Under `CTRL_STEP_EN` with `step_mode`=1, the FSM waits in FETCH until `step` is sampled high.
